mem_burst_ctrl: RTL and testbench
=================================

MEM_BURST_CTRL -- requirements
Module: mem_burst_ctrl

Interface
REQ-001 Parameters: ADDR_WIDTH 32, byte address width; DATA_WIDTH 64, beat width; BURST_LENGTH 8, beats per line; MEM_DEPTH 1024, 64-bit words stored; ACCESS_LATENCY 4, cycles from request accept to first beat.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req  input  1  L2 request; sampled only in IDLE.
REQ-005 we_MEM  input  1  1 = read (memory supplies line), 0 = write (L2 supplies line); L2 polarity.
REQ-006 addr_MEM  input  ADDR_WIDTH  byte address of requested word.
REQ-007 data_in  input  DATA_WIDTH  write data from L2.
REQ-008 data_out  output  DATA_WIDTH  read data to L2.
REQ-009 data_oe  output  1  1 while block drives the shared 64-bit memory bus; the tristate sits outside this block.
REQ-010 stb  output  1  beat strobe; every edge, rising or falling, marks one beat.
REQ-011 busy  output  1  high from request accept through DONE.
REQ-012 done  output  1  one-cycle pulse when a burst completes.

Function
REQ-013 The FSM SHALL have states IDLE, LATENCY, BURST and DONE.
REQ-014 In IDLE with req=1, the block SHALL latch we_MEM and addr_MEM, clear the latency counter, set busy and enter LATENCY.
REQ-015 LATENCY SHALL last exactly ACCESS_LATENCY cycles, then enter BURST.
REQ-016 Beat word index SHALL be {addr_MEM[12:6], (addr_MEM[5:3]+k) mod 8} for beat k=0..7 (critical word first, wrap within the 64-byte line); addr_MEM[2:0] and bits above 12 are ignored (aliasing).
REQ-017 Read beat k SHALL use two cycles: cycle 2k loads data_out from the array; cycle 2k+1 toggles stb with data_out held stable.
REQ-018 Write beat k SHALL use two cycles: cycle 2k toggles stb; cycle 2k+1 samples data_in and writes it to the array.
REQ-019 data_oe SHALL be 1 only in BURST of a read, else 0.
REQ-020 After beat 7 the block SHALL enter DONE for one cycle with done=1, then return to IDLE with busy=0.
REQ-021 Each burst SHALL produce exactly 8 stb toggles, so stb ends each burst at its starting level.
REQ-022 req while busy SHALL be ignored and not queued; req held high in IDLE after DONE SHALL start a new burst.
REQ-023 A read of a word never written SHALL return the array's unknown/initial content; no defined value is required.

Reset
REQ-024 Asserting reset SHALL immediately force IDLE, stb=0, busy=0, done=0, data_oe=0, data_out=0, and clear all counters.
REQ-025 Reset mid-burst SHALL abort with no further array writes; words written before reset SHALL be retained, since the array is not cleared.

Structure
REQ-026 Package mem_burst_pkg SHALL hold the FSM state encoding, BURST_LENGTH, DATA_WIDTH and the read/write we_MEM polarity constants.
REQ-027 Storage SHALL be a separate sub-module mem_array: a single-port, synchronous-write, 1024x64 array without reset.

Verification
REQ-028 Write addr 0x00000040, data 0x1111_0000_0000_000k for k=0..7 -> 8 stb toggles; then read 0x40 -> beats return the same 8 values in order.
REQ-029 Read addr 0x00000058 after REQ-028 -> beat order word 3,4,5,6,7,0,1,2 (wrap); first stb toggle occurs 4+2 cycles after accept.
REQ-030 req pulsed again during BURST -> ignored; exactly one done pulse and 8 toggles.
REQ-031 reset asserted after 3 write beats to 0x80 -> next cycle stb=0, busy=0, data_oe=0; readback shows words 0-2 updated and words 3-7 unchanged.
REQ-032 Address 0x00002040 after REQ-028 -> aliases to 0x40 and returns the same data.
REQ-033 req held high continuously -> back-to-back bursts each separated by the single DONE cycle, with busy low for one cycle in IDLE.

Source files
------------

// File: rtl/mem_burst_pkg.sv
// Shared types and constants for the L2-to-memory burst controller.
package mem_burst_pkg;

   localparam int unsigned BURST_LENGTH = 8;
   localparam int unsigned DATA_WIDTH   = 64;

   // we_MEM polarity as seen from L2: high requests a line read from memory.
   localparam logic WE_READ  = 1'b1;
   localparam logic WE_WRITE = 1'b0;

   typedef enum logic [1:0] {
      StIdle,
      StLatency,
      StBurst,
      StDone
   } state_e;

endpackage

// File: rtl/mem_array.sv
// Single-port word array: synchronous write, combinational read, no reset.
module mem_array #(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned WIDTH = 64
) (
   input  logic                     clk_i,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] addr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_burst_ctrl.sv
// Memory-side burst controller: serves one 8-beat critical-word-first line per L2 request.
module mem_burst_ctrl #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 64,
   parameter int unsigned BURST_LENGTH   = 8,
   parameter int unsigned MEM_DEPTH      = 1024,
   parameter int unsigned ACCESS_LATENCY = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req,
   input  logic                  we_MEM,
   input  logic [ADDR_WIDTH-1:0] addr_MEM,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_oe,
   output logic                  stb,
   output logic                  busy,
   output logic                  done
);

   import mem_burst_pkg::*;

   localparam int unsigned WordAw   = $clog2(MEM_DEPTH);
   localparam int unsigned ByteOffW = $clog2(DATA_WIDTH / 8);
   localparam int unsigned BeatW    = $clog2(BURST_LENGTH);
   localparam int unsigned LatW     = $clog2(ACCESS_LATENCY + 1);

   localparam logic [LatW-1:0]  LatLast  = LatW'(ACCESS_LATENCY - 1);
   localparam logic [BeatW-1:0] BeatLast = BeatW'(BURST_LENGTH - 1);

   state_e                  state_q, state_d;
   logic [LatW-1:0]         lat_q, lat_d;
   logic [BeatW-1:0]        beat_q, beat_d;
   logic                    phase_q, phase_d;
   logic                    we_q, we_d;
   logic [WordAw-1:0]       addr_q, addr_d;
   logic                    stb_q, stb_d;
   logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;

   logic                    mem_we;
   logic [WordAw-1:0]       mem_addr;
   logic [DATA_WIDTH-1:0]   mem_rdata;

   // Byte offset and bits above the array are aliased away.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{addr_MEM[ADDR_WIDTH-1:ByteOffW+WordAw], addr_MEM[ByteOffW-1:0]};

   // Line base stays fixed; only the in-line word index advances and wraps.
   assign mem_addr = {addr_q[WordAw-1:BeatW], addr_q[BeatW-1:0] + beat_q};

   always_comb begin
      state_d    = state_q;
      lat_d      = lat_q;
      beat_d     = beat_q;
      phase_d    = phase_q;
      we_d       = we_q;
      addr_d     = addr_q;
      stb_d      = stb_q;
      data_out_d = data_out_q;
      mem_we     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (req) begin
               we_d    = we_MEM;
               addr_d  = addr_MEM[ByteOffW +: WordAw];
               lat_d   = '0;
               beat_d  = '0;
               phase_d = 1'b0;
               state_d = StLatency;
            end
         end

         StLatency: begin
            if (lat_q == LatLast) begin
               state_d = StBurst;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end

         StBurst: begin
            // Read: fetch then strobe. Write: strobe then capture data_in.
            if (!phase_q) begin
               if (we_q == WE_READ) begin
                  data_out_d = mem_rdata;
               end else begin
                  stb_d = ~stb_q;
               end
            end else begin
               if (we_q == WE_READ) begin
                  stb_d = ~stb_q;
               end else begin
                  mem_we = 1'b1;
               end
               beat_d = beat_q + 1'b1;
               if (beat_q == BeatLast) begin
                  state_d = StDone;
               end
            end
            phase_d = ~phase_q;
         end

         StDone: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         lat_q      <= '0;
         beat_q     <= '0;
         phase_q    <= 1'b0;
         we_q       <= WE_WRITE;
         addr_q     <= '0;
         stb_q      <= 1'b0;
         data_out_q <= '0;
      end else begin
         state_q    <= state_d;
         lat_q      <= lat_d;
         beat_q     <= beat_d;
         phase_q    <= phase_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         stb_q      <= stb_d;
         data_out_q <= data_out_d;
      end
   end

   assign data_out = data_out_q;
   assign stb      = stb_q;
   assign busy     = (state_q != StIdle);
   assign done     = (state_q == StDone);
   assign data_oe  = (state_q == StBurst) && (we_q == WE_READ);

   mem_array #(
      .DEPTH (MEM_DEPTH),
      .WIDTH (DATA_WIDTH)
   ) u_mem_array (
      .clk_i   (clk),
      .we_i    (mem_we),
      .addr_i  (mem_addr),
      .wdata_i (data_in),
      .rdata_o (mem_rdata)
   );

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Directed bench for mem_burst_ctrl with a strobe-following L2 model.
module tb_mem_burst_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic        we_MEM;
   logic [31:0] addr_MEM;
   logic [63:0] data_in;
   logic [63:0] data_out;
   logic        data_oe;
   logic        stb;
   logic        busy;
   logic        done;

   always #5 clk = ~clk;

   mem_burst_ctrl dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .we_MEM   (we_MEM),
      .addr_MEM (addr_MEM),
      .data_in  (data_in),
      .data_out (data_out),
      .data_oe  (data_oe),
      .stb      (stb),
      .busy     (busy),
      .done     (done)
   );

   int n_vec = 0;
   int n_err = 0;

   logic [63:0] wbuf [8];
   logic [63:0] rbuf [8];
   logic [63:0] old_line [8];
   int toggles, first_j, done_j, idle_j, dones, oe_bad;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Issues one request and follows it cycle by cycle; j counts negedges after the accept edge.
   task automatic run_burst(input logic rd, input logic [31:0] a, input int abort_beats,
                            input bit poke_req);
      logic stb_prev;
      int   last_tog;
      @(negedge clk);
      req      = 1'b1;
      we_MEM   = rd;
      addr_MEM = a;
      @(posedge clk);
      #1 req = 1'b0;
      stb_prev = stb;
      toggles  = 0;
      first_j  = -1;
      done_j   = -1;
      idle_j   = -1;
      dones    = 0;
      oe_bad   = 0;
      last_tog = -10;
      for (int j = 0; j < 40; j++) begin
         @(negedge clk);
         if (data_oe !== (rd && j >= 4 && j <= 19)) oe_bad++;
         if (stb !== stb_prev) begin
            stb_prev = stb;
            last_tog = j;
            if (first_j < 0) first_j = j;
            if (toggles < 8) begin
               if (rd) rbuf[toggles] = data_out;
               else data_in = wbuf[toggles];
            end
            toggles++;
         end
         if (done === 1'b1) begin
            dones++;
            done_j = j;
         end
         if (poke_req && j == 8) req = 1'b1;
         if (poke_req && j == 9) req = 1'b0;
         if (abort_beats < 8 && toggles == abort_beats && j == last_tog + 1) begin
            reset = 1'b1;
            break;
         end
         if (busy === 1'b0) begin
            idle_j = j;
            break;
         end
      end
   endtask

   task automatic check_burst(input string name, input int exp_first);
      check_eq({name, "_toggles"}, 64'(toggles), 64'd8);
      check_eq({name, "_first_stb"}, 64'(first_j), 64'(exp_first));
      check_eq({name, "_done_cyc"}, 64'(done_j), 64'd20);
      check_eq({name, "_done_cnt"}, 64'(dones), 64'd1);
      check_eq({name, "_idle_cyc"}, 64'(idle_j), 64'd21);
      check_eq({name, "_oe"}, 64'(oe_bad), 64'd0);
      check_eq({name, "_stb_end"}, {63'd0, stb}, 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n_idle;
      int n_done;
      int first_idle;
      reset    = 1'b1;
      req      = 1'b0;
      we_MEM   = 1'b0;
      addr_MEM = '0;
      data_in  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_stb", {63'd0, stb}, 64'd0);
      check_eq("rst_busy", {63'd0, busy}, 64'd0);
      check_eq("rst_done", {63'd0, done}, 64'd0);
      check_eq("rst_oe", {63'd0, data_oe}, 64'd0);
      check_eq("rst_data_out", data_out, 64'd0);
      reset = 1'b0;

      // Write line at 0x40, then read it back in order.
      for (int k = 0; k < 8; k++) wbuf[k] = 64'h1111_0000_0000_0000 + 64'(k);
      run_burst(1'b0, 32'h0000_0040, 8, 1'b0);
      check_burst("wr40", 5);

      run_burst(1'b1, 32'h0000_0040, 8, 1'b0);
      check_burst("rd40", 6);
      for (int k = 0; k < 8; k++)
         check_eq($sformatf("rd40_b%0d", k), rbuf[k], 64'h1111_0000_0000_0000 + 64'(k));

      // Critical word 3 first, wrapping within the line.
      run_burst(1'b1, 32'h0000_0058, 8, 1'b0);
      check_burst("rd58", 6);
      for (int k = 0; k < 8; k++)
         check_eq($sformatf("rd58_b%0d", k), rbuf[k],
                  64'h1111_0000_0000_0000 + 64'((k + 3) % 8));

      // A req pulse mid-burst must neither disturb nor queue.
      run_burst(1'b1, 32'h0000_0040, 8, 1'b1);
      check_burst("poke", 6);
      repeat (3) @(negedge clk);
      check_eq("poke_no_queue", {63'd0, busy}, 64'd0);

      // Upper address bits alias.
      run_burst(1'b1, 32'h0000_2040, 8, 1'b0);
      check_burst("alias", 6);
      for (int k = 0; k < 8; k++)
         check_eq($sformatf("alias_b%0d", k), rbuf[k], 64'h1111_0000_0000_0000 + 64'(k));

      // Reset after three write beats to 0x80.
      for (int k = 0; k < 8; k++) begin
         old_line[k] = 64'hAAAA_0000_0000_0000 + 64'(k);
         wbuf[k]     = old_line[k];
      end
      run_burst(1'b0, 32'h0000_0080, 8, 1'b0);
      check_burst("wr80", 5);
      for (int k = 0; k < 8; k++) wbuf[k] = 64'hBBBB_0000_0000_0000 + 64'(k);
      run_burst(1'b0, 32'h0000_0080, 3, 1'b0);
      check_eq("abort_toggles", 64'(toggles), 64'd3);
      @(posedge clk);
      #1;
      check_eq("abort_stb", {63'd0, stb}, 64'd0);
      check_eq("abort_busy", {63'd0, busy}, 64'd0);
      check_eq("abort_oe", {63'd0, data_oe}, 64'd0);
      check_eq("abort_done", {63'd0, done}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      run_burst(1'b1, 32'h0000_0080, 8, 1'b0);
      check_burst("rd80", 6);
      for (int k = 0; k < 8; k++)
         check_eq($sformatf("rd80_b%0d", k), rbuf[k], (k < 3) ? wbuf[k] : old_line[k]);

      // req held high: back-to-back bursts with one idle cycle between.
      @(negedge clk);
      req        = 1'b1;
      we_MEM     = 1'b1;
      addr_MEM   = 32'h0000_0040;
      n_idle     = 0;
      n_done     = 0;
      first_idle = -1;
      for (int j = 0; j < 66; j++) begin
         @(negedge clk);
         if (busy === 1'b0) begin
            n_idle++;
            if (first_idle < 0) first_idle = j;
         end
         if (done === 1'b1) n_done++;
         if (j == 65) req = 1'b0;
      end
      check_eq("b2b_idle_cnt", 64'(n_idle), 64'd3);
      check_eq("b2b_done_cnt", 64'(n_done), 64'd3);
      check_eq("b2b_first_idle", 64'(first_idle), 64'd21);
      repeat (3) @(negedge clk);
      check_eq("b2b_stop_busy", {63'd0, busy}, 64'd0);
      check_eq("b2b_stb_end", {63'd0, stb}, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
